// File: rtl/down_timer_pkg.sv
// Shared types and constants for the down_timer block: FSM state encoding and prescaler width.
// Pure declarations; no logic, no latency.
package down_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int PRESC_W = 16;

endpackage

// File: rtl/down_timer_prescaler.sv
// Cycle divider: tick is combinational, high on the en cycle where the count sits at PRESCALE-1.
// clr and rst force the count to 0; the count holds while en is low.
module down_timer_prescaler
  import down_timer_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam logic [PRESC_W-1:0] TOP = PRESC_W'(PRESCALE - 1);

  logic [PRESC_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (r_cnt == TOP) r_cnt <= '0;
      else              r_cnt <= r_cnt + PRESC_W'(1);
    end
  end

  assign tick = en && (r_cnt == TOP);

endmodule

// File: rtl/down_timer.sv
// Loadable down counter with IDLE/RUN/PAUSE control; out/expired registered, one step per PRESCALE cycles.
// DOWN_TIMER_AUTORELOAD_EN selects periodic reload at terminal count; otherwise one-shot to 0 and IDLE.
module down_timer
  import down_timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             expired
);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_reload;
  logic             r_expired;
  logic             w_en;
  logic             w_tick;

  // The prescaler freezes on the cycle stop lands so PAUSE keeps its phase.
  assign w_en = (r_state == RUN) && !stop && !wr;

  down_timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (wr),
    .en   (w_en),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_out     <= '0;
      r_reload  <= '0;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (wr) begin
        r_reload <= wr_data;
        r_out    <= wr_data;
        r_state  <= (wr_data != '0) ? RUN : IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !stop && (r_out != '0)) r_state <= RUN;
          end
          PAUSE: begin
            if (start && !stop) r_state <= RUN;
          end
          RUN: begin
            if (stop) begin
              r_state <= PAUSE;
            end else if (w_tick) begin
              if (r_out > WIDTH'(1)) begin
                r_out <= r_out - WIDTH'(1);
              end else if (r_out == WIDTH'(1)) begin
                r_expired <= 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
                r_out     <= r_reload;
`else
                r_out     <= '0;
                r_state   <= IDLE;
`endif
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign out     = r_out;
  assign busy    = (r_state == RUN);
  assign expired = r_expired;

endmodule

// File: tb/tb_down_timer.sv
// Drives two down_timer instances (PRESCALE 1 and 4) with shared stimulus against a cycle model.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr = 1'b0, start = 1'b0, stop = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic [7:0] out1, out4;
  logic       busy1, busy4, exp1, exp4;
  logic [19:0] w_dut;

  int n_vec = 0;
  int n_err = 0;

  // Model: per instance, count, reload, cycles into the current step, mode (0 idle, 1 run, 2 pause).
  int m_out[2], m_rel[2], m_ph[2], m_st[2];
  bit m_exp[2];
  int m_p[2] = '{1, 4};

  always #5 clk = ~clk;

  down_timer #(.WIDTH(8), .PRESCALE(1)) u1 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr(wr), .start(start), .stop(stop),
    .out(out1), .busy(busy1), .expired(exp1)
  );

  down_timer #(.WIDTH(8), .PRESCALE(4)) u4 (
    .clk(clk), .rst(rst), .wr_data(wr_data), .wr(wr), .start(start), .stop(stop),
    .out(out4), .busy(busy4), .expired(exp4)
  );

  assign w_dut = {out1, busy1, exp1, out4, busy4, exp4};

  function automatic logic [19:0] mdl();
    return {8'(m_out[0]), m_st[0] == 1, m_exp[0], 8'(m_out[1]), m_st[1] == 1, m_exp[1]};
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      m_exp[d] = 1'b0;
      if (rst) begin
        m_out[d] = 0; m_rel[d] = 0; m_ph[d] = 0; m_st[d] = 0;
      end else if (wr) begin
        m_rel[d] = wr_data; m_out[d] = wr_data; m_ph[d] = 0;
        m_st[d] = (wr_data != 0) ? 1 : 0;
      end else if (m_st[d] == 0) begin
        if (start && !stop && m_out[d] != 0) m_st[d] = 1;
      end else if (m_st[d] == 2) begin
        if (start && !stop) m_st[d] = 1;
      end else if (stop) begin
        m_st[d] = 2;
      end else begin
        m_ph[d] = m_ph[d] + 1;
        if (m_ph[d] == m_p[d]) begin
          m_ph[d] = 0;
          if (m_out[d] > 1) m_out[d] = m_out[d] - 1;
          else begin
            m_exp[d] = 1'b1;
`ifdef DOWN_TIMER_AUTORELOAD_EN
            m_out[d] = m_rel[d];
`else
            m_out[d] = 0;
            m_st[d]  = 0;
`endif
          end
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit w, input bit s, input bit t, input logic [7:0] d);
    rst = r; wr = w; start = s; stop = t; wr_data = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 0, 0);
      n_vec++;
      if (w_dut !== mdl()) begin n_err++; $display("FAIL reset_hold: got %h want %h", w_dut, mdl()); end
    end
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (w_dut !== 20'h0) begin n_err++; $display("FAIL reset_release: got %h want %h", w_dut, 20'h0); end
    end
  endtask

  task automatic test_load55();
    int first = -1;
    int cnt = 0;
`ifdef DOWN_TIMER_AUTORELOAD_EN
    int len = 115; int want_cnt = 2;
`else
    int len = 60;  int want_cnt = 1;
`endif
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 8'd55);
    n_vec++;
    if (out1 !== 8'd55 || busy1 !== 1'b1) begin
      n_err++; $display("FAIL load55_first: got out=%0d busy=%b want out=55 busy=1", out1, busy1);
    end
    for (int i = 1; i <= len; i++) begin
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (w_dut !== mdl()) begin n_err++; $display("FAIL load55_cycle%0d: got %h want %h", i, w_dut, mdl()); end
      if (exp1) begin cnt++; if (first < 0) first = i; end
    end
    n_vec++;
    if (first != 55) begin n_err++; $display("FAIL load55_expire_at: got %0d want 55", first); end
    n_vec++;
    if (cnt != want_cnt) begin n_err++; $display("FAIL load55_expire_count: got %0d want %0d", cnt, want_cnt); end
  endtask

  task automatic test_prescale4();
    int first = -1;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 8'd3);
    for (int i = 1; i <= 16; i++) begin
      step(0, 0, 0, 0, 0);
      n_vec++;
      if (w_dut !== mdl()) begin n_err++; $display("FAIL presc4_cycle%0d: got %h want %h", i, w_dut, mdl()); end
      if (exp4 && first < 0) first = i;
    end
    n_vec++;
    if (first != 12) begin n_err++; $display("FAIL presc4_expire_at: got %0d want 12", first); end
  endtask

  task automatic test_pause();
    int n = 0;
    bit seen = 0;
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 8'd10);
    while (out1 !== 8'd6 && n < 20) begin step(0, 0, 0, 0, 0); n++; end
    n_vec++;
    if (out1 !== 8'd6) begin n_err++; $display("FAIL pause_reach6: got %0d want 6", out1); end
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 1, 0);
      n_vec++;
      if (out1 !== 8'd6 || busy1 !== 1'b0 || w_dut !== mdl()) begin
        n_err++; $display("FAIL pause_hold%0d: got %h want %h", i, w_dut, mdl());
      end
    end
    step(0, 0, 1, 0, 0);
    n = 0;
    while (!seen && n < 20) begin
      step(0, 0, 0, 0, 0); n++;
      n_vec++;
      if (w_dut !== mdl()) begin n_err++; $display("FAIL resume_cycle%0d: got %h want %h", n, w_dut, mdl()); end
      seen = exp1;
    end
    n_vec++;
    if (!seen || n != 6) begin n_err++; $display("FAIL resume_expire_at: got %0d want 6", n); end
  endtask

  task automatic test_priority();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 8'd9);
    n_vec++;
    if (busy1 !== 1'b1 || out1 !== 8'd9) begin
      n_err++; $display("FAIL wr_over_stop: got busy=%b out=%0d want busy=1 out=9", busy1, out1);
    end
    step(0, 0, 1, 1, 0);
    n_vec++;
    if (busy1 !== 1'b0 || w_dut !== mdl()) begin
      n_err++; $display("FAIL stop_over_start: got %h want %h", w_dut, mdl());
    end
    step(0, 1, 0, 0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (w_dut !== 20'h0) begin n_err++; $display("FAIL load_zero%0d: got %h want %h", i, w_dut, 20'h0); end
      step(0, 0, (i == 2), 0, 0);
    end
  endtask

  task automatic test_rst_midrun();
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 8'd30);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
    n_vec++;
    if (out1 !== 8'd20) begin n_err++; $display("FAIL midrun_at20: got %0d want 20", out1); end
    step(1, 1, 1, 0, 8'd77);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (w_dut !== 20'h0) begin n_err++; $display("FAIL rst_abort%0d: got %h want %h", i, w_dut, 20'h0); end
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_random();
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 6, 8'($urandom_range(0, 12)));
      n_vec++;
      if (w_dut !== mdl()) begin n_err++; $display("FAIL random%0d: got %h want %h", i, w_dut, mdl()); end
    end
  endtask

  initial begin
    test_reset();
    test_load55();
    test_prescale4();
    test_pause();
    test_priority();
    test_rst_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: width of count and load value.
REQ-002 SHALL have parameter PRESCALE, default 1, legal 1..65535: clock cycles per count step.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port wr_data  input  WIDTH: load/reload value.
REQ-006 SHALL have port wr  input  1: load wr_data into count and reload registers and arm the timer.
REQ-007 SHALL have port start  input  1: resume or restart counting.
REQ-008 SHALL have port stop  input  1: pause counting.
REQ-009 SHALL have port out  output  WIDTH: current count, registered.
REQ-010 SHALL have port busy  output  1: high while the state is RUN.
REQ-011 SHALL have port expired  output  1: one-cycle pulse on terminal count.

Function
REQ-012 SHALL implement the states IDLE, RUN and PAUSE.
REQ-013 On wr, SHALL set reload and out to wr_data and clear the prescaler; next state RUN if wr_data != 0, else IDLE.
REQ-014 wr SHALL take priority over start and stop in the same cycle.
REQ-015 If start and stop are asserted together, SHALL let stop win.
REQ-016 On start in IDLE with out != 0, or in PAUSE, SHALL go to RUN; start in IDLE with out == 0 SHALL be ignored.
REQ-017 On stop in RUN, SHALL go to PAUSE, holding out and the prescaler value; stop in IDLE or PAUSE SHALL have no effect.
REQ-018 In RUN, SHALL assert tick when the prescaler reaches PRESCALE-1, then wrap the prescaler to 0.
REQ-019 On tick with out > 1, SHALL decrement out by 1.
REQ-020 On tick with out == 1, SHALL pulse expired for exactly one cycle, registered, in the same cycle the terminal value appears on out (see Configuration).
REQ-021 With PRESCALE=1 and wr of N at edge k, SHALL hold out = N-j after edge k+j, with expired high after edge k+N.
REQ-022 Loading wr_data=0 SHALL produce no expired pulse.
REQ-023 out SHALL never underflow or wrap below 0.
REQ-024 A wr in RUN SHALL restart from the new value with no expired pulse for the aborted run.

Reset
REQ-025 On rst, SHALL set out=0, reload=0, prescaler=0, state=IDLE, busy=0 and expired=0 at the next edge.
REQ-026 rst SHALL override wr, start and stop.
REQ-027 rst during RUN SHALL abort the run with no expired pulse.

Configuration
REQ-028 SHALL use macro DOWN_TIMER_AUTORELOAD_EN to select terminal-count behaviour.
REQ-029 With DOWN_TIMER_AUTORELOAD_EN defined: at terminal count, SHALL load out with reload, pulse expired and stay in RUN (periodic mode); out SHALL not show 0.
REQ-030 Without DOWN_TIMER_AUTORELOAD_EN: at terminal count, SHALL set out=0, pulse expired and go to IDLE (one-shot mode).

Structure
REQ-031 Package down_timer_pkg SHALL hold the state enum (IDLE, RUN, PAUSE) and the prescaler width constant (16).
REQ-032 The prescaler SHALL be the sub-module down_timer_prescaler, with ports clk, rst, clr, en and tick.

Verification
REQ-033 Reset held 10 cycles, then released -> out=0, busy=0, expired=0 throughout.
REQ-034 PRESCALE=1, wr with wr_data=55 -> out counts 55..1; expired exactly once, 55 cycles after load; one-shot: out=0, busy=0; autoreload: out=55 and continues, expired every 55 cycles.
REQ-035 PRESCALE=4, wr with wr_data=3 -> out steps every 4 cycles; expired 12 cycles after load.
REQ-036 wr 10, stop at out=6 for 20 cycles, then start -> out holds 6 while paused; expired 6 ticks after resume.
REQ-037 Same-cycle wr+stop, then start+stop, then wr_data=0 -> RUN; then PAUSE; then IDLE with no expired pulse.
REQ-038 rst mid-run at out=20 -> out=0 next cycle, IDLE, no expired pulse.
